miner_job_ctrl: RTL
===================

# miner_job_ctrl

Job dispatcher and result collector on the host side of the hashing core. Accepts a 44-byte work unit as a byte stream, presents midstate/data2 and the nonce partition to the core, and generates the start_mining pulse. Tracks miner_busy/got_ticket through the run, then emits a 4-byte result (golden nonce) on an outbound byte stream toward the UART transmitter.

## Interface
- START_CYCLES, 4, cycles start_mining is held high (core double-synchronises it)
- BUSY_TIMEOUT, 16, cycles to wait for miner_busy after start before abandoning
- TICKET_WAIT, 8, cycles after miner_busy falls to wait for got_ticket
- NONCE_START, 4'h0, driven on nonce_start
- NONCE_MASK, 4'h0, driven on nonce_start_mask

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  job byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- out_data  out  8  result byte
- out_valid  out  1  out_data valid
- out_ready  in  1  byte consumed when out_valid & out_ready
- midstate  out  256  to core
- data2  out  96  to core
- nonce_start  out  4  NONCE_START
- nonce_start_mask  out  4  NONCE_MASK
- start_mining  out  1  start request to core
- miner_busy  in  1  core running
- got_ticket  in  1  core found nonce (sticky until next start)
- golden_nonce  in  32  valid while got_ticket

## Operation
- Staging buffer (352 b) + byte counter 0..43. Byte k<32 -> staging midstate[8k+7:8k]; byte k>=32 -> staging data2[8(k-32)+7:8(k-32)]. Counter wraps 43->0 on accept of the final byte; that accept is "job complete".
- in_ready = 1 in IDLE, WAIT_BUSY, MINING, DRAIN; 0 in START and REPORT.
- FSM states: IDLE, START, WAIT_BUSY, MINING, DRAIN, REPORT.
  - Job complete (any state where in_ready=1): copy staging to midstate/data2 outputs next cycle; go START (aborts any run in progress; no result sent for the aborted job).
  - START: start_mining=1 for exactly START_CYCLES cycles, then WAIT_BUSY.
  - WAIT_BUSY: miner_busy=1 -> MINING; BUSY_TIMEOUT cycles elapsed -> IDLE.
  - MINING: miner_busy=0 -> DRAIN (counter cleared).
  - DRAIN: got_ticket=1 -> capture golden_nonce, REPORT; TICKET_WAIT cycles elapsed without ticket -> exhausted (see Configuration).
  - REPORT: send captured nonce bytes 0..3, LSB first (nonce[7:0] first); after 4th handshake -> IDLE.
- got_ticket sampled only in DRAIN (core clears work before raising got_ticket; stale high from prior job ignored as start clears it in the core).
- midstate/data2 outputs change only on job-complete copy; stable through START..REPORT.

## Timing
- Reset values: in_ready 0 during reset then 1 (IDLE), out_valid 0, out_data 0, start_mining 0, midstate 0, data2 0, byte counter 0, FSM IDLE.
- Job complete at cycle T: outputs updated and start_mining=1 at T+1 through T+START_CYCLES.
- out_valid asserted first cycle in REPORT; out_data/out_valid held until out_ready; next byte presented the cycle after handshake; no bubble required.
- Job completing in the same cycle miner_busy falls: job wins (START).
- rst mid-operation: partial frame discarded, pending result dropped, all outputs to reset values next cycle.
- Byte counter advances only on handshake; in_valid without in_ready has no effect.

## Configuration
- MINER_EXHAUST_REPORT_EN defined: DRAIN timeout enters REPORT with captured value 32'hFFFFFFFF (exhaustion marker, 4 bytes 0xFF).
- Undefined: DRAIN timeout returns to IDLE silently; out_valid never asserted for exhausted jobs.

## Test plan
- Reset then 44 bytes 0x00..0x2B -> midstate[7:0]=0x00, midstate[255:248]=0x1F, data2[7:0]=0x20, data2[95:88]=0x2B; start_mining high exactly 4 cycles starting cycle after byte 43.
- Core model: busy 6 cycles after start, busy falls, got_ticket 2 cycles later with golden_nonce=0x12345678 -> out bytes 0x78,0x56,0x34,0x12; out_ready toggled 1/0 -> each byte held until handshake.
- Busy never rises -> IDLE after 16 cycles in WAIT_BUSY, no output, in_ready=1.
- Busy falls, no ticket for 8 cycles -> with MINER_EXHAUST_REPORT_EN four 0xFF bytes; without, no out_valid.
- Second full job delivered while MINING -> new start_mining pulse, outputs hold second job, first job's ticket never reported.
- rst asserted after 20 job bytes -> next 44 bytes form a complete job (counter restarted at 0).

Source files
------------

// File: rtl/miner_job_if.sv
// miner_job_if: inbound job byte stream and outbound result byte stream
interface miner_job_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: job dispatcher/result collector for the hashing core; MINER_EXHAUST_REPORT_EN reports 0xFFFFFFFF on ticket timeout
module miner_job_ctrl #(
    parameter int         START_CYCLES = 4,
    parameter int         BUSY_TIMEOUT = 16,
    parameter int         TICKET_WAIT  = 8,
    parameter logic [3:0] NONCE_START  = 4'h0,
    parameter logic [3:0] NONCE_MASK   = 4'h0
) (
    input  logic           clk,
    input  logic           rst,
    miner_job_if.slave     stream,
    output logic [255:0]   midstate,
    output logic [95:0]    data2,
    output logic [3:0]     nonce_start,
    output logic [3:0]     nonce_start_mask,
    output logic           start_mining,
    input  logic           miner_busy,
    input  logic           got_ticket,
    input  logic [31:0]    golden_nonce
);
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, MINING, DRAIN, REPORT} state_t;

    state_t       state;
    logic [5:0]   byte_cnt;
    logic [351:0] staging;
    logic [351:0] staging_next;
    logic [7:0]   timer;
    logic [31:0]  nonce;
    logic [1:0]   byte_idx;
    logic         accept;
    logic         job_done;

    assign nonce_start      = NONCE_START;
    assign nonce_start_mask = NONCE_MASK;
    assign stream.in_ready  = !rst && state != START && state != REPORT;
    assign accept           = stream.in_valid && stream.in_ready;
    assign job_done         = accept && byte_cnt == 6'd43;

    // staging image including the byte being accepted this cycle, so the final byte lands in the copy
    always_comb begin
        staging_next = staging;
        if (accept) staging_next[byte_cnt*8 +: 8] = stream.in_data;
    end

    // byte counter and staging buffer advance only on an accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (accept) begin
            staging  <= staging_next;
            byte_cnt <= job_done ? 6'd0 : byte_cnt + 6'd1;
        end
    end

    // run sequencing; a completed job pre-empts whatever run is in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            timer            <= '0;
            start_mining     <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            midstate         <= '0;
            data2            <= '0;
            nonce            <= '0;
            byte_idx         <= '0;
        end else if (job_done) begin
            {data2, midstate} <= staging_next;
            state             <= START;
            start_mining      <= 1'b1;
            timer             <= '0;
        end else begin
            timer <= timer + 8'd1;
            case (state)
                START: if (timer == 8'(START_CYCLES - 1)) begin
                    state        <= WAIT_BUSY;
                    start_mining <= 1'b0;
                    timer        <= '0;
                end
                WAIT_BUSY: if (miner_busy) state <= MINING;
                    else if (timer == 8'(BUSY_TIMEOUT - 1)) state <= IDLE;
                MINING: if (!miner_busy) begin
                    state <= DRAIN;
                    timer <= '0;
                end
                DRAIN: if (got_ticket) begin
                    state            <= REPORT;
                    nonce            <= golden_nonce;
                    stream.out_valid <= 1'b1;
                    stream.out_data  <= golden_nonce[7:0];
                    byte_idx         <= '0;
                end else if (timer == 8'(TICKET_WAIT - 1)) begin
`ifdef MINER_EXHAUST_REPORT_EN
                    state            <= REPORT;
                    nonce            <= 32'hFFFF_FFFF;
                    stream.out_valid <= 1'b1;
                    stream.out_data  <= 8'hFF;
                    byte_idx         <= '0;
`else
                    state <= IDLE;
`endif
                end
                REPORT: if (stream.out_ready) begin
                    if (byte_idx == 2'd3) begin
                        stream.out_valid <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        byte_idx        <= byte_idx + 2'd1;
                        nonce           <= nonce >> 8;
                        stream.out_data <= nonce[15:8];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
